// File: rtl/rd_pkg.sv
// ----------------------------------------------------------------------------
// rd_pkg
// Shared constants and helpers for the rd_popcount_pipe slice.
//   RD_GRP     : bits per counting group (stage-1 split width)
//   RD_WW      : width of one group weight (0..RD_GRP)
//   rd_clog2   : ceiling log2, used to size the word popcount
//   rd_ngrp    : number of RD_GRP-bit groups covering an n-bit word
// ----------------------------------------------------------------------------
package rd_pkg;

   localparam int unsigned RD_GRP = 5;
   localparam int unsigned RD_WW  = 3;

   // Smallest r with 2**r >= v (rd_clog2(1) = 0).
   function automatic int unsigned rd_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(v)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Groups needed once the word is zero-padded to a multiple of RD_GRP.
   function automatic int unsigned rd_ngrp(input int unsigned n);
      return (n + RD_GRP - 1) / RD_GRP;
   endfunction

endpackage : rd_pkg

// File: rtl/rd_grp_count.sv
// ----------------------------------------------------------------------------
// rd_grp_count
// Combinational ones-count of one RD_GRP-bit group.
//   i_bits   : group bits (input, RD_GRP)
//   o_weight : number of ones in i_bits, 0..RD_GRP (output, RD_WW)
// ----------------------------------------------------------------------------
module rd_grp_count
   import rd_pkg::*;
(
   input  logic [RD_GRP-1:0] i_bits,
   output logic [RD_WW-1:0]  o_weight
);

   // Plain adder chain; five bits is small enough that the tool picks the tree.
   always_comb begin
      o_weight = '0;
      for (int unsigned i = 0; i < RD_GRP; i++) begin
         o_weight = o_weight + RD_WW'(i_bits[i]);
      end
   end

endmodule : rd_grp_count

// File: rtl/rd_popcount_pipe.sv
// ----------------------------------------------------------------------------
// rd_popcount_pipe
// Two-stage population-count pipeline with optional per-packet accumulation.
//   Stage 1 registers one weight per 5-bit group of the input word.
//   Stage 2 sums the weights, adds the packet accumulator (mode 1) and
//   registers the result onto the output interface.
//
// Parameters
//   N      : input word width, 5..64
//   AW     : count / accumulator width, AW >= clog2(N+1)
//   THRESH : compare level for out_thresh
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  : input handshake; in_ready = !out_valid | out_ready
//   in_data [N]        : word to count
//   in_last            : final beat of a packet (accumulate mode only)
//   mode               : 0 = per-word count, 1 = accumulate over a packet
//   out_valid/out_ready: output handshake
//   out_count [AW]     : ones counted (saturating in accumulate mode)
//   out_ovf            : accumulated count saturated
//   out_thresh         : out_count >= THRESH (only with RD_POPCOUNT_THRESH_EN)
//
// Build option
//   RD_POPCOUNT_THRESH_EN : adds the registered out_thresh port.
// ----------------------------------------------------------------------------
module rd_popcount_pipe
   import rd_pkg::*;
#(
   parameter int unsigned N      = 16,
   parameter int unsigned AW     = 8,
   parameter int unsigned THRESH = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic          in_last,
   input  logic          mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_count,
   output logic          out_ovf
`ifdef RD_POPCOUNT_THRESH_EN
   ,
   output logic          out_thresh
`endif
);

   localparam int unsigned NG = rd_ngrp(N);
   localparam int unsigned NP = NG * RD_GRP;
   localparam int unsigned PW = rd_clog2(N + 1);
   localparam int unsigned SW = AW + 1;

   // Reject configurations the datapath cannot represent.
   if (N < 5 || N > 64) begin : g_bad_n
      $error("rd_popcount_pipe: N must be in 5..64");
   end
   if (AW < PW || AW > 32) begin : g_bad_aw
      $error("rd_popcount_pipe: AW must hold N and be at most 32");
   end
   if (64'(THRESH) > ((64'(1) << AW) - 64'(1))) begin : g_bad_thresh
      $error("rd_popcount_pipe: THRESH must be representable in AW bits");
   end

   // ---------------------------------------------------------------------
   // Handshake: the whole pipe moves together whenever the output slot frees
   // ---------------------------------------------------------------------
   logic w_adv;
   logic w_accept;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;
   assign w_accept = in_valid && w_adv;

   // ---------------------------------------------------------------------
   // Packet framing: mode is taken from the first beat and held until last
   // ---------------------------------------------------------------------
   logic r_in_pkt;
   logic r_mode;
   logic w_mode_eff;
   logic w_last_eff;

   assign w_mode_eff = r_in_pkt ? r_mode : mode;
   // Mode-0 words, and single-beat packets, are always their own result.
   assign w_last_eff = !w_mode_eff || in_last;

   // ---------------------------------------------------------------------
   // Stage 1: zero-pad, split into groups, count each group
   // ---------------------------------------------------------------------
   logic [NP-1:0]             w_pad;
   logic [NG-1:0][RD_WW-1:0]  w_wt;

   assign w_pad = NP'(in_data);

   for (genvar g = 0; g < NG; g++) begin : g_grp
      rd_grp_count u_grp (
         .i_bits   (w_pad[g*RD_GRP +: RD_GRP]),
         .o_weight (w_wt[g])
      );
   end

   logic                      r_s1_valid;
   logic                      r_s1_last;
   logic [NG-1:0][RD_WW-1:0]  r_s1_wt;

   // Stage-1 register and packet framing state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_wt    <= '0;
         r_in_pkt   <= 1'b0;
         r_mode     <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         if (w_accept) begin
            r_s1_wt   <= w_wt;
            r_s1_last <= w_last_eff;
            r_in_pkt  <= !w_last_eff;
            r_mode    <= w_mode_eff;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: word popcount, accumulate, saturate
   // ---------------------------------------------------------------------
   logic [PW-1:0] w_pop;
   logic [AW-1:0] r_acc;
   logic          r_acc_ovf;
   logic [SW-1:0] w_sum;
   logic          w_sat;
   logic [AW-1:0] w_res;
   logic          w_ovf;

   // Sum of group weights = popcount of the word.
   always_comb begin
      w_pop = '0;
      for (int unsigned g = 0; g < NG; g++) begin
         w_pop = w_pop + PW'(r_s1_wt[g]);
      end
   end

   // The accumulator is zero outside a packet, so mode-0 words pass unchanged
   // and can never saturate (AW always covers N).
   assign w_sum = SW'(r_acc) + SW'(w_pop);
   assign w_sat = w_sum[AW];
   assign w_res = w_sat ? '1 : w_sum[AW-1:0];
   // Once saturated the accumulator pins at all-ones; the sticky flag keeps
   // the overflow visible through to the packet's final result.
   assign w_ovf = r_acc_ovf || w_sat;

   // Output register and accumulator; everything freezes while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_count <= '0;
         out_ovf   <= 1'b0;
         r_acc     <= '0;
         r_acc_ovf <= 1'b0;
      end else if (w_adv) begin
         out_valid <= r_s1_valid && r_s1_last;
         if (r_s1_valid) begin
            if (r_s1_last) begin
               out_count <= w_res;
               out_ovf   <= w_ovf;
               r_acc     <= '0;
               r_acc_ovf <= 1'b0;
            end else begin
               r_acc     <= w_res;
               r_acc_ovf <= w_ovf;
            end
         end
      end
   end

`ifdef RD_POPCOUNT_THRESH_EN
   // Threshold flag registered alongside out_count so it shares the hold rule.
   logic w_thresh;

   assign w_thresh = 64'(w_res) >= 64'(THRESH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_thresh <= 1'b0;
      end else if (w_adv && r_s1_valid && r_s1_last) begin
         out_thresh <= w_thresh;
      end
   end
`endif

endmodule : rd_popcount_pipe

// File: tb/tb_rd_popcount_pipe.sv
// ----------------------------------------------------------------------------
// tb_rd_popcount_pipe
// Self-checking bench for rd_popcount_pipe (N=16, AW=8, THRESH=12).
// Inputs change 1 time unit after the rising edge; the monitor samples on
// the falling edge, where inputs and outputs are both settled.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rd_popcount_pipe;

   localparam int unsigned N      = 16;
   localparam int unsigned AW     = 8;
   localparam int unsigned THRESH = 12;
   localparam int unsigned MAXC   = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic          in_last;
   logic          mode;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_count;
   logic          out_ovf;
`ifdef RD_POPCOUNT_THRESH_EN
   logic          out_thresh;
`endif

   rd_popcount_pipe #(.N(N), .AW(AW), .THRESH(THRESH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_ovf    (out_ovf)
`ifdef RD_POPCOUNT_THRESH_EN
      ,
      .out_thresh (out_thresh)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit rnd_ordy = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Reference model: packet-level arithmetic over a queue of results
   // ------------------------------------------------------------------
   typedef struct {
      int unsigned cnt;
      logic        ovf;
   } res_t;

   res_t        exp_q[$];
   bit          m_in_pkt = 1'b0;
   bit          m_mode   = 1'b0;
   int unsigned m_acc    = 0;
   logic          p_v   = 1'b0;
   logic          p_r   = 1'b0;
   logic          p_ovf = 1'b0;
   logic [AW-1:0] p_cnt = '0;
   bit            p_rst = 1'b1;

   always @(negedge clk) begin
      res_t        e;
      int unsigned pc;
      if (rst) begin
         exp_q.delete();
         m_in_pkt = 1'b0;
         m_acc    = 0;
      end else begin
         chk("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (p_v && !p_r && !p_rst) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_count", out_count, p_cnt);
            chk("hold_ovf", out_ovf, p_ovf);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("model_count", out_count, e.cnt);
               chk("model_ovf", out_ovf, e.ovf);
            end
         end
`ifdef RD_POPCOUNT_THRESH_EN
         if (out_valid) chk("model_thresh", out_thresh, (int'(out_count) >= int'(THRESH)));
`endif
         if (in_valid && in_ready) begin
            pc = $countones(in_data);
            if (!m_in_pkt) begin
               m_mode = mode;
               m_acc  = 0;
            end
            if (!m_mode) begin
               exp_q.push_back('{pc, 1'b0});
            end else begin
               m_acc = m_acc + pc;
               if (in_last) begin
                  exp_q.push_back('{(m_acc > MAXC) ? MAXC : m_acc, (m_acc > MAXC)});
                  m_in_pkt = 1'b0;
               end else begin
                  m_in_pkt = 1'b1;
               end
            end
         end
      end
      p_v   = out_valid;
      p_r   = out_ready;
      p_cnt = out_count;
      p_ovf = out_ovf;
      p_rst = rst;
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ordy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Present one beat and return 1 unit after the edge that accepted it.
   task automatic send(input logic [N-1:0] d, input logic lst, input logic md);
      int unsigned b;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = lst;
      mode     = md;
      b = 0;
      while (!in_ready && b < 50) begin
         tick();
         b++;
      end
      if (!in_ready) chk("send_timeout", 0, 1);
      else tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int unsigned c;
      c = 0;
      while (!out_valid && c < 40) begin
         tick();
         c++;
      end
      if (!out_valid) chk("wait_timeout", 0, 1);
   endtask

   typedef struct {
      logic        md;
      logic [15:0] d;
      logic        lst;
      int unsigned cnt;
   } vec_t;

   vec_t tbl[14];
   int   got[$];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      tbl[0]  = '{1'b0, 16'hFFFF, 1'b0, 16};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 0};
      tbl[2]  = '{1'b0, 16'h0001, 1'b0, 1};
      tbl[3]  = '{1'b0, 16'hAAAA, 1'b0, 8};
      tbl[4]  = '{1'b0, 16'h8001, 1'b1, 2};
      tbl[5]  = '{1'b0, 16'h1234, 1'b0, 5};
      tbl[6]  = '{1'b0, 16'hF0F0, 1'b0, 8};
      tbl[7]  = '{1'b0, 16'h7FFF, 1'b1, 15};
      tbl[8]  = '{1'b0, 16'h8000, 1'b0, 1};
      tbl[9]  = '{1'b1, 16'h000F, 1'b1, 4};
      tbl[10] = '{1'b1, 16'h00FF, 1'b1, 8};
      tbl[11] = '{1'b1, 16'h5555, 1'b1, 8};
      tbl[12] = '{1'b1, 16'hC003, 1'b1, 4};
      tbl[13] = '{1'b1, 16'hFFF0, 1'b1, 12};

      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      mode      = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_ovf", out_ovf, 0);
`ifdef RD_POPCOUNT_THRESH_EN
      chk("rst_out_thresh", out_thresh, 0);
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);

      // Single-result vectors: exact 2-cycle latency and value.
      foreach (tbl[i]) begin
         send(tbl[i].d, tbl[i].lst, tbl[i].md);
         chk($sformatf("tbl%0d_not_early", i), out_valid, 0);
         tick();
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_count", i), out_count, tbl[i].cnt);
         chk($sformatf("tbl%0d_ovf", i), out_ovf, 0);
`ifdef RD_POPCOUNT_THRESH_EN
         chk($sformatf("tbl%0d_thresh", i), out_thresh, (tbl[i].cnt >= THRESH));
`endif
         tick();
      end

      // Back-to-back words, one result per cycle.
      send(16'h0000, 1'b0, 1'b0);
      send(16'h0001, 1'b0, 1'b0);
      chk("b2b_v0", out_valid, 1);
      chk("b2b_c0", out_count, 0);
      send(16'hAAAA, 1'b0, 1'b0);
      chk("b2b_v1", out_valid, 1);
      chk("b2b_c1", out_count, 1);
      tick();
      chk("b2b_v2", out_valid, 1);
      chk("b2b_c2", out_count, 8);
      tick();
      chk("b2b_end", out_valid, 0);

      // Three-beat packet; mode on later beats must be ignored.
      send(16'h00FF, 1'b0, 1'b1);
      send(16'h0F0F, 1'b0, 1'b0);
      chk("pkt_no_early", out_valid, 0);
      send(16'h0003, 1'b1, 1'b0);
      wait_valid();
      chk("pkt_count", out_count, 18);
      chk("pkt_ovf", out_ovf, 0);
      tick();

      // Saturation, then the flag clears with the next packet.
      for (int k = 0; k < 16; k++) send(16'hFFFF, 1'b0, 1'b1);
      send(16'hFFFF, 1'b1, 1'b1);
      wait_valid();
      chk("sat_count", out_count, 255);
      chk("sat_ovf", out_ovf, 1);
      tick();
      send(16'h0001, 1'b1, 1'b1);
      wait_valid();
      chk("post_sat_count", out_count, 1);
      chk("post_sat_ovf", out_ovf, 0);
      tick();

      // Downstream stall for 4 cycles with two results queued behind.
      out_ready = 1'b0;
      send(16'h00FF, 1'b1, 1'b0);
      send(16'h0F00, 1'b1, 1'b0);
      in_valid = 1'b1;
      in_data  = 16'h0007;
      in_last  = 1'b1;
      mode     = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_valid", out_valid, 1);
         chk("stall_count", out_count, 8);
         tick();
      end
      out_ready = 1'b1;
      got.delete();
      for (int k = 0; k < 8; k++) begin
         if (out_valid) got.push_back(int'(out_count));
         tick();
         if (k == 0) in_valid = 1'b0;
      end
      chk("stall_n_results", got.size(), 3);
      if (got.size() >= 3) begin
         chk("stall_order0", got[0], 8);
         chk("stall_order1", got[1], 4);
         chk("stall_order2", got[2], 3);
      end

      // Reset in the middle of an accumulating packet.
      send(16'hFFFF, 1'b0, 1'b1);
      send(16'hFFFF, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_count", out_count, 0);
      chk("midrst_ovf", out_ovf, 0);
      tick();
      tick();
      rst = 1'b0;
      send(16'h000F, 1'b1, 1'b1);
      wait_valid();
      chk("midrst_next_count", out_count, 4);
      chk("midrst_next_ovf", out_ovf, 0);
      tick();

      // Randomized traffic with random back-pressure against the model.
      rnd_ordy = 1'b1;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 4) == 0) tick();
         send(16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
      send(16'($urandom), 1'b1, 1'b1);
      rnd_ordy  = 1'b0;
      out_ready = 1'b1;
      repeat (6) tick();
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_idle", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_rd_popcount_pipe

// File: doc/rd_popcount_pipe.md
RD_POPCOUNT_PIPE -- requirements
Module: rd_popcount_pipe

Interface
REQ-001 SHALL have parameter N, default 16: input word width in bits, legal range 5..64.
REQ-002 SHALL have parameter AW, default 8: count/accumulator width, AW >= clog2(N+1).
REQ-003 SHALL have parameter THRESH, default 12: compare level for out_thresh.
REQ-004 SHALL have port clk, input, 1: the only clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: in_data, in_last and mode are valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, N: word to be counted.
REQ-009 SHALL have port in_last, input, 1: final beat of a packet, used in accumulate mode only.
REQ-010 SHALL have port mode, input, 1: 0 = per-word count, 1 = accumulate over a packet.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_count, output, AW: number of ones counted.
REQ-014 SHALL have port out_ovf, output, 1: accumulated count saturated.
REQ-015 SHALL have port out_thresh, output, 1: out_count >= THRESH; present only under RD_POPCOUNT_THRESH_EN.

Function
REQ-016 SHALL advance the pipeline when adv = !out_valid | out_ready, and SHALL drive in_ready = adv.
REQ-017 SHALL accept a beat only when in_valid & in_ready are both high.
REQ-018 Stage 1 SHALL zero-pad in_data to a multiple of 5, split it into 5-bit groups, and register one 3-bit weight (0..5) per group.
REQ-019 Stage 2 SHALL sum the group weights to the word popcount (0..N).
REQ-020 In mode 0, the result SHALL appear on out_valid exactly 2 cycles after acceptance when there is no stall, and in_last SHALL be ignored.
REQ-021 In mode 1, each word popcount SHALL be added to an AW-bit accumulator; only the in_last beat SHALL produce out_valid, with out_count equal to the accumulator plus that beat's popcount, and the accumulator SHALL clear in that same cycle.
REQ-022 Mode SHALL be latched from the first beat of a packet, and mode on later beats of the same packet SHALL be ignored until in_last.
REQ-023 An accumulated sum above 2^AW-1 SHALL saturate at 2^AW-1 and set out_ovf for that result; out_ovf SHALL clear with the next packet and SHALL be 0 in mode 0.
REQ-024 out_valid, out_count and out_ovf SHALL hold stable while out_valid & !out_ready.
REQ-025 Back-to-back beats SHALL sustain 1 beat/cycle with no bubbles when out_ready is held high.
REQ-026 A single-beat packet (mode 1 with in_last on the first beat) SHALL behave identically to mode 0.

Reset
REQ-027 rst SHALL asynchronously force out_valid=0, out_count=0, out_ovf=0, out_thresh=0, all stage valids=0, accumulator=0 and latched mode=0.
REQ-028 Reset asserted mid-packet SHALL discard the partial accumulation, and the first accepted beat after reset SHALL start a new packet.
REQ-029 in_ready SHALL be 1 while rst is deasserted and out_valid=0.

Configuration
REQ-030 With RD_POPCOUNT_THRESH_EN defined, port out_thresh SHALL exist, be registered with out_count, and obey the REQ-024 hold rule.
REQ-031 Without RD_POPCOUNT_THRESH_EN, the out_thresh port and its compare logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-032 Package rd_pkg SHALL hold the clog2 helper, the group-size constant RD_GRP=5, and the function giving the number of groups for N.
REQ-033 Sub-module rd_grp_count (5-bit in, 3-bit weight out, combinational) SHALL be instantiated once per group.
REQ-034 The stall/valid handshake and the accumulator SHALL reside in rd_popcount_pipe.

Verification (N=16, AW=8, THRESH=12)
REQ-035 Mode 0, in_data=16'hFFFF, out_ready=1 -> out_count=16 two cycles later, out_thresh=1.
REQ-036 Mode 0, words 16'h0000, 16'h0001, 16'hAAAA on consecutive cycles -> out_count 0, 1, 8 on consecutive cycles, with no bubbles.
REQ-037 Mode 1, packet 16'h00FF, 16'h0F0F, 16'h0003 with last on the third beat -> one result, out_count=18, out_ovf=0.
REQ-038 Mode 1, 17 beats of 16'hFFFF -> out_count=255, out_ovf=1, and the next single-beat packet of 16'h0001 gives out_count=1, out_ovf=0.
REQ-039 Hold out_ready=0 for 4 cycles with a result pending -> in_ready=0 and out_count stable; on release the data is delivered in order with no loss.
REQ-040 Assert rst after 2 beats of a mode 1 packet -> all outputs 0, and a following single-beat packet of 16'h000F gives out_count=4.
